pipeline_hazard_unit: RTL and testbench
=======================================

# pipeline_hazard_unit

Parametrised hazard, forwarding and pipeline-control unit for the in-order CPU pipeline. It keeps a scoreboard of the instructions in flight after decode, and from it produces stall, bubble, flush and freeze controls for fetch, decode and execute, plus the forwarding selects for the execute operand muxes. It adds interlocking, bypass selection, branch squashing and memory-wait freezing across a configurable number of back-end stages.

## Interface
- `STAGES`, 3 — post-decode stages tracked: stage 0 = EX, stage 1 = MEM, stage `STAGES-1` = WB; legal range 3..6.
- `REG_ADDR_W`, 5 — register address width.
- `FORWARD_EN`, 1 — 1: bypassing enabled; 0: interlock-only, stall until the producer reaches WB.
- `CNT_W`, 16 — width of the hazard stall counter.
- `FWD_W`, `$clog2(STAGES)` — forwarding select width (derived, not overridable).

Ports:
- `clock` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `id_valid` in 1 — decode holds a valid instruction.
- `id_rs1`, `id_rs2` in `REG_ADDR_W` — source registers of the decode instruction.
- `id_uses_rs1`, `id_uses_rs2` in 1 — the source is actually read.
- `id_rd` in `REG_ADDR_W` — destination register of the decode instruction.
- `id_reg_write` in 1 — the decode instruction writes `id_rd`.
- `id_mem_read` in 1 — the decode instruction is a load.
- `mem_busy` in 1 — the memory stage has not completed; inverse of mem_done.
- `branch_taken` in 1 — the instruction currently in EX redirects the PC.
- `stall_if`, `stall_id` out 1 — hold the PC and the IF/ID register.
- `bubble_ex` out 1 — load a NOP into EX instead of the decode instruction.
- `flush_if_id` out 1 — squash the IF/ID contents.
- `freeze` out 1 — whole pipeline holds.
- `fwd_a`, `fwd_b` out `FWD_W` — operand source for the instruction in EX.
- `hazard_count` out `CNT_W` — saturating count of data-hazard stall cycles.

## Operation
- **Scoreboard entries.** Each entry `sb[s]`, for s = 0..`STAGES-1`, holds {valid, rd, reg_write, mem_read}.
- **match(s, r).** True when `sb[s]`.valid & reg_write & rd == r & r != 0. Register x0 never matches.
- **Data hazard on one source.** For a used source r, a hazard exists in stage s when match(s, r) is true and either:
  - `FORWARD_EN` = 0 and s < `STAGES-1`, or
  - `FORWARD_EN` = 1 and `sb[s]`.mem_read and s == 0 (load-use; load data is first available at the MEM output).
- **Data hazard overall.** `id_valid` & any hazard on either used source.
- **Freeze.** `freeze` = `mem_busy`. While frozen:
  - `stall_if` = `stall_id` = 1, `bubble_ex` = 0, `flush_if_id` = 0;
  - scoreboard, `fwd_a/b` and `hazard_count` hold.
- **Flush.** `flush_if_id` = `branch_taken` & ~`mem_busy`. On flush, `bubble_ex` = 1 and `stall_if` = `stall_id` = 0. Flush has priority over a data hazard.
- **Stall.** On a data hazard without flush or freeze: `stall_if` = `stall_id` = `bubble_ex` = 1, and `hazard_count` increments, saturating at all-ones.
- **Advance (not frozen).**
  - `sb[s+1]` <= `sb[s]`.
  - `sb[0]` <= decode fields when `id_valid` & ~stall & ~flush; otherwise `sb[0]`.valid <= 0.
- **Forwarding select, per source, registered on advance.** The select is computed against the pre-advance scoreboard. The youngest matching s (lowest s) wins:
  - s < `STAGES-1` → code s+1, meaning the output pipeline register of stage s (1 = EX/MEM, 2 = MEM/WB);
  - match only in `STAGES-1`, or no match → code 0, the register bank (written at this edge);
  - source unused, bubble inserted, or `FORWARD_EN` = 0 → code 0.

## Timing
- **Reset.** All `sb` valid = 0, `fwd_a` = `fwd_b` = 0, `hazard_count` = 0 on the first edge with `reset` = 1.
  - `stall_*`, `bubble_ex` and `flush_if_id` are 0 after reset unless `branch_taken` is asserted.
  - `freeze` follows `mem_busy` combinationally, including during reset.
- **Combinational outputs.** `stall_if`, `stall_id`, `bubble_ex`, `flush_if_id` and `freeze` are combinational from the registered scoreboard and the inputs, with no cycle of latency.
- **Registered outputs.** `fwd_a` and `fwd_b` are registered; they are valid in the cycle the consumer occupies EX.
- **Load-use.** Exactly 1 stall cycle with `FORWARD_EN` = 1; the consumer then issues with code 2.
- **Interlock-only.** With `FORWARD_EN` = 0, a back-to-back dependency stalls `STAGES-1` cycles.
- **Reset mid-stall.** Outputs return to idle on the cycle after the reset edge.
- **Counter saturation.** `hazard_count` at all-ones stays there under further stalls.

## Test plan
- `STAGES` = 3, `FORWARD_EN` = 1: add x5 then add x6,x5,x1 back-to-back → no stall; next cycle `fwd_a` = 1, `fwd_b` = 0.
- lw x7 then add x8,x7,x7 → one cycle with `stall_if` = `stall_id` = `bubble_ex` = 1; next cycle `fwd_a` = `fwd_b` = 2; `hazard_count` = 1.
- Producer writes x0, consumer reads x0 → no stall, `fwd_a` = 0.
- Load-use hazard with `branch_taken` = 1 in the same cycle → `flush_if_id` = 1, `bubble_ex` = 1, stalls 0, `hazard_count` unchanged.
- `mem_busy` = 1 for 3 cycles during a load-use stall → `freeze` = 1 for those 3 cycles, scoreboard and fwd held, `hazard_count` held. After release, 1 stall cycle, then issue with code 2.
- `FORWARD_EN` = 0 back-to-back dependency → 2 stall cycles, issue with code 0. Repeat the run with `reset` pulsed during the first stall cycle → next cycle all stall outputs 0, `hazard_count` = 0.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: scoreboard-driven interlock, forwarding select, flush and freeze control
module pipeline_hazard_unit #(
  parameter int STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W = 16,
  localparam int FWD_W = $clog2(STAGES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  mem_busy,
  input  logic                  branch_taken,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic                  freeze,
  output logic [FWD_W-1:0]      fwd_a,
  output logic [FWD_W-1:0]      fwd_b,
  output logic [CNT_W-1:0]      hazard_count
);
  logic [STAGES-1:0] sb_valid, sb_we, sb_mr;
  logic [REG_ADDR_W-1:0] sb_rd [STAGES];
  logic [STAGES-1:0] m1, m2, h1, h2;
  logic [FWD_W-1:0] sel1, sel2;
  logic hazard, stall, flush, issue;
  always_comb begin
    m1 = '0;
    m2 = '0;
    h1 = '0;
    h2 = '0;
    sel1 = '0;
    sel2 = '0;
    for (int s = 0; s < STAGES; s++) begin
      m1[s] = sb_valid[s] & sb_we[s] & (sb_rd[s] == id_rs1) & (id_rs1 != '0);
      m2[s] = sb_valid[s] & sb_we[s] & (sb_rd[s] == id_rs2) & (id_rs2 != '0);
      h1[s] = m1[s] & (FORWARD_EN ? (sb_mr[s] & (s == 0)) : (s < STAGES - 1));
      h2[s] = m2[s] & (FORWARD_EN ? (sb_mr[s] & (s == 0)) : (s < STAGES - 1));
    end
    // scan oldest to youngest so the youngest producer wins; WB stage maps to the register bank
    for (int s = STAGES - 2; s >= 0; s--) begin
      sel1 = m1[s] ? FWD_W'(s + 1) : sel1;
      sel2 = m2[s] ? FWD_W'(s + 1) : sel2;
    end
  end
  assign hazard = id_valid & ((id_uses_rs1 & |h1) | (id_uses_rs2 & |h2));
  assign freeze = mem_busy;
  assign flush = branch_taken & ~mem_busy;
  assign stall = hazard & ~flush & ~mem_busy;
  assign issue = id_valid & ~stall & ~flush;
  assign flush_if_id = flush;
  assign stall_if = mem_busy | stall;
  assign stall_id = mem_busy | stall;
  assign bubble_ex = ~mem_busy & (flush | stall);
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_valid <= '0;
      fwd_a <= '0;
      fwd_b <= '0;
      hazard_count <= '0;
    end else if (!mem_busy) begin
      sb_valid <= {sb_valid[STAGES-2:0], issue};
      sb_we <= {sb_we[STAGES-2:0], id_reg_write};
      sb_mr <= {sb_mr[STAGES-2:0], id_mem_read};
      sb_rd[0] <= id_rd;
      for (int s = 1; s < STAGES; s++) sb_rd[s] <= sb_rd[s-1];
      fwd_a <= (FORWARD_EN && issue && id_uses_rs1) ? sel1 : '0;
      fwd_b <= (FORWARD_EN && issue && id_uses_rs2) ? sel2 : '0;
      hazard_count <= (stall && !(&hazard_count)) ? hazard_count + 1'b1 : hazard_count;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed checks of forwarding (dut1) and interlock-only (dut0) configurations
module tb_pipeline_hazard_unit;
  logic clock = 1'b0;
  logic reset, id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, mem_busy, branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic stall_if1, stall_id1, bubble1, flush1, freeze1;
  logic [1:0] fwd_a1, fwd_b1;
  logic [15:0] hc1;
  logic stall_if0, stall_id0, bubble0, flush0, freeze0;
  logic [1:0] fwd_a0, fwd_b0;
  logic [1:0] hc0;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  pipeline_hazard_unit #(.STAGES(3), .REG_ADDR_W(5), .FORWARD_EN(1'b1), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .mem_busy(mem_busy), .branch_taken(branch_taken),
    .stall_if(stall_if1), .stall_id(stall_id1), .bubble_ex(bubble1), .flush_if_id(flush1),
    .freeze(freeze1), .fwd_a(fwd_a1), .fwd_b(fwd_b1), .hazard_count(hc1));
  pipeline_hazard_unit #(.STAGES(3), .REG_ADDR_W(5), .FORWARD_EN(1'b0), .CNT_W(2)) dut0 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .mem_busy(mem_busy), .branch_taken(branch_taken),
    .stall_if(stall_if0), .stall_id(stall_id0), .bubble_ex(bubble0), .flush_if_id(flush0),
    .freeze(freeze0), .fwd_a(fwd_a0), .fwd_b(fwd_b0), .hazard_count(hc0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic ins(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                     input logic u2, input logic [4:0] rd, input logic rw, input logic mr,
                     input logic busy, input logic br);
    id_valid = v;
    id_rs1 = r1;
    id_rs2 = r2;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_rd = rd;
    id_reg_write = rw;
    id_mem_read = mr;
    mem_busy = busy;
    branch_taken = br;
    #1;
  endtask
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask
  initial begin
    reset = 1'b1;
    @(negedge clock);
    ins(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("freeze_in_reset", freeze1, 1);
    step();
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall_if", stall_if1, 0);
    chk("rst_bubble", bubble1, 0);
    chk("rst_flush", flush1, 0);
    chk("rst_fwd_a", fwd_a1, 0);
    chk("rst_fwd_b", fwd_b1, 0);
    chk("rst_count", hc1, 0);
    reset = 1'b0;
    ins(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    chk("alu_prod_nostall", stall_id1, 0);
    step();
    ins(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    chk("alu_b2b_nostall", stall_if1, 0);
    step();
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_fwd_a", fwd_a1, 1);
    chk("alu_fwd_b", fwd_b1, 0);
    ins(1, 1, 0, 1, 0, 7, 1, 1, 0, 0);
    step();
    ins(1, 7, 7, 1, 1, 8, 1, 0, 0, 0);
    chk("lu_stall_if", stall_if1, 1);
    chk("lu_stall_id", stall_id1, 1);
    chk("lu_bubble", bubble1, 1);
    step();
    chk("lu_released", stall_id1, 0);
    chk("lu_count", hc1, 1);
    step();
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_fwd_a", fwd_a1, 2);
    chk("lu_fwd_b", fwd_b1, 2);
    ins(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    step();
    ins(1, 0, 0, 1, 1, 9, 1, 0, 0, 0);
    chk("x0_nostall", stall_id1, 0);
    step();
    chk("x0_fwd", fwd_a1, 0);
    ins(1, 1, 0, 1, 0, 10, 1, 1, 0, 0);
    step();
    ins(1, 10, 0, 1, 0, 11, 1, 0, 0, 1);
    chk("flush_flag", flush1, 1);
    chk("flush_bubble", bubble1, 1);
    chk("flush_stall_if", stall_if1, 0);
    chk("flush_stall_id", stall_id1, 0);
    step();
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_no_count", hc1, 1);
    chk("flush_fwd", fwd_a1, 0);
    step();
    step();
    ins(1, 1, 0, 1, 0, 14, 1, 0, 0, 0);
    step();
    ins(1, 14, 0, 1, 0, 12, 1, 1, 0, 0);
    step();
    chk("fz_pre_fwd", fwd_a1, 1);
    ins(1, 12, 0, 1, 0, 13, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("fz_freeze", freeze1, 1);
      chk("fz_stall_id", stall_id1, 1);
      chk("fz_bubble", bubble1, 0);
      step();
      chk("fz_fwd_held", fwd_a1, 1);
      chk("fz_count_held", hc1, 1);
    end
    ins(1, 12, 0, 1, 0, 13, 1, 0, 0, 0);
    chk("fz_post_freeze", freeze1, 0);
    chk("fz_post_stall", stall_id1, 1);
    chk("fz_post_bubble", bubble1, 1);
    step();
    chk("fz_count", hc1, 2);
    chk("fz_released", stall_id1, 0);
    step();
    chk("fz_fwd", fwd_a1, 2);
    reset = 1'b1;
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    chk("il_rst_count", hc0, 0);
    ins(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    step();
    ins(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    chk("il_stall1_if", stall_if0, 1);
    chk("il_stall1_bubble", bubble0, 1);
    step();
    chk("il_stall2", stall_id0, 1);
    step();
    chk("il_released", stall_id0, 0);
    chk("il_count", hc0, 2);
    step();
    chk("il_fwd0", fwd_a0, 0);
    reset = 1'b1;
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    ins(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    step();
    ins(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    chk("mid_rst_stall", stall_id0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_stall_if", stall_if0, 0);
    chk("mid_rst_stall_id", stall_id0, 0);
    chk("mid_rst_bubble", bubble0, 0);
    chk("mid_rst_count", hc0, 0);
    ins(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    step();
    ins(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    step();
    step();
    chk("sat_count2", hc0, 2);
    step();
    ins(1, 6, 1, 1, 1, 7, 1, 0, 0, 0);
    chk("sat_stall", stall_id0, 1);
    step();
    chk("sat_count3", hc0, 3);
    chk("sat_stall2", stall_id0, 1);
    step();
    chk("sat_hold", hc0, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
